// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between instruction fetch and load/store requesters.
// Define ARB_RR_EN for round-robin arbitration; the default is fixed D-over-IF priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              grant_d,
  output logic              timeout_err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_GRANT_IF = 2'd1,
    S_GRANT_D  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_mem_read, w_mem_read_nxt;
  logic                r_mem_write, w_mem_write_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic [CNT_W-1:0]    r_wait_cnt, w_wait_cnt_nxt;
  logic                r_timeout_err, w_timeout_err_nxt;
  logic                w_busy;
  logic                w_timeout;
  logic                w_finish;
  logic                w_pick_d;

  assign w_busy    = (r_state != S_IDLE);
  assign w_timeout = (TIMEOUT > 0) && w_busy && (r_wait_cnt == CNT_LAST) && !mem_ack;
  assign w_finish  = w_busy && (mem_ack || w_timeout);

`ifdef ARB_RR_EN
  // r_last_d: 1 = most recent grant went to D, 0 = IF
  logic r_last_d;

  assign w_pick_d = d_req && (!if_req || !r_last_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_d <= 1'b0;
    end else if (r_state == S_IDLE && (d_req || if_req)) begin
      r_last_d <= w_pick_d;
    end
  end
`else
  assign w_pick_d = d_req;
`endif

  always_comb begin
    w_state_nxt       = r_state;
    w_mem_read_nxt    = r_mem_read;
    w_mem_write_nxt   = r_mem_write;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_wdata_nxt   = r_mem_wdata;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_timeout_err_nxt = r_timeout_err;
    case (r_state)
      S_IDLE: begin
        w_mem_read_nxt  = 1'b0;
        w_mem_write_nxt = 1'b0;
        w_wait_cnt_nxt  = '0;
        if (d_req || if_req) begin
          if (w_pick_d) begin
            w_state_nxt     = S_GRANT_D;
            w_mem_read_nxt  = !d_we;
            w_mem_write_nxt = d_we;
            w_mem_addr_nxt  = d_addr;
            w_mem_wdata_nxt = d_wdata;
          end else begin
            w_state_nxt     = S_GRANT_IF;
            w_mem_read_nxt  = 1'b1;
            w_mem_write_nxt = 1'b0;
            w_mem_addr_nxt  = if_addr;
            w_mem_wdata_nxt = '0;
          end
        end
      end
      S_GRANT_IF, S_GRANT_D: begin
        if (w_finish) begin
          w_state_nxt     = S_IDLE;
          w_mem_read_nxt  = 1'b0;
          w_mem_write_nxt = 1'b0;
          w_wait_cnt_nxt  = '0;
          // an ack on the last allowed cycle still counts as success
          if (!mem_ack) w_timeout_err_nxt = 1'b1;
        end else if (r_wait_cnt != CNT_MAX) begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_mem_read_nxt  = 1'b0;
        w_mem_write_nxt = 1'b0;
        w_wait_cnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_mem_read    <= w_mem_read_nxt;
      r_mem_write   <= w_mem_write_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  // done is suppressed while reset is held so an abandoned grant never completes
  assign if_done     = !reset && w_finish && (r_state == S_GRANT_IF);
  assign d_done      = !reset && w_finish && (r_state == S_GRANT_D);
  assign if_rdata    = w_timeout ? '0 : mem_rdata;
  assign d_rdata     = w_timeout ? '0 : mem_rdata;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign busy        = w_busy;
  assign grant_d     = (r_state == S_GRANT_D);
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a small memory model acks after a set latency,
// expected accesses are queued when requests are driven and checked at each done pulse.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          busy;
  logic          grant_d;
  logic          timeout_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .grant_d(grant_d), .timeout_err(timeout_err)
  );

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ncyc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   mcnt = 0;
  int   mem_lat = 1;
  bit   if_sticky = 1'b0;
  bit   d_sticky = 1'b0;
  int   acc_left = 0;
  bit   prev_done = 1'b0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void push(input bit is_d, input bit we, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rd, input int n);
    exp_t e;
    e.is_d = is_d; e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd; e.ncyc = n;
    q.push_back(e);
  endfunction

  // one clock: memory model responds at the falling edge, outputs sampled just after
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (mem_read || mem_write) begin
      mcnt++;
      mem_ack = (mem_lat != 0) && (mcnt == mem_lat);
    end else begin
      mcnt = 0;
      mem_ack = 1'b0;
    end
    mem_rdata = mem_ack ? mem_model(mem_addr) : 32'hBAD0_BAD0;
    #1;
    if (prev_done) chk_val("idle_after_done", 64'(busy), 64'(0));
    prev_done = if_done || d_done;
    if (if_done || d_done) begin
      if (q.size() == 0) begin
        chk_val("unexpected_done", 64'(1), 64'(0));
      end else begin
        e = q.pop_front();
        chk_val("done_port_d", 64'(d_done), 64'(e.is_d));
        chk_val("grant_d", 64'(grant_d), 64'(e.is_d));
        chk_val("busy_at_done", 64'(busy), 64'(1));
        chk_val("mem_addr", 64'(mem_addr), 64'(e.addr));
        chk_val("mem_write", 64'(mem_write), 64'(e.we));
        chk_val("mem_read", 64'(mem_read), 64'(!e.we));
        chk_val("strobe_cycles", 64'(mcnt), 64'(e.ncyc));
        if (e.we) chk_val("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
        else      chk_val("rdata", 64'(e.is_d ? d_rdata : if_rdata), 64'(e.rdata));
      end
      if (if_done && !if_sticky) if_req = 1'b0;
      if (d_done && !d_sticky) d_req = 1'b0;
      if (acc_left > 0) begin
        acc_left--;
        if (acc_left == 0) begin
          if_req = 1'b0;
          d_req = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      step();
      n++;
    end
    if (q.size() != 0) begin
      chk_val("wait_budget", 64'(q.size()), 64'(0));
      q.delete();
      if_req = 1'b0;
      d_req = 1'b0;
    end
    step();
  endtask

  initial begin
    repeat (2) step();
    chk_val("reset_flags", 64'({mem_read, mem_write, busy, grant_d, timeout_err, if_done, d_done}), 64'(0));
    chk_val("reset_addr", 64'(mem_addr), 64'(0));
    chk_val("reset_wdata", 64'(mem_wdata), 64'(0));
    reset = 1'b0;
    step();

    // lone fetch, ack on the third strobe cycle
    mem_lat = 3;
    if_addr = 32'h10; if_req = 1'b1;
    push(1'b0, 1'b0, 32'h10, 32'h0, mem_model(32'h10), 3);
    wait_done();

    // store with immediate ack
    mem_lat = 1;
    d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    push(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0, 1);
    wait_done();

    // contention, both requesters held for four accesses
    mem_lat = 2;
    d_we = 1'b0; d_addr = 32'h80; if_addr = 32'h20;
    if_sticky = 1'b1; d_sticky = 1'b1; acc_left = 4;
`ifdef ARB_RR_EN
    for (int i = 0; i < 2; i++) begin
      push(1'b1, 1'b0, 32'h80, 32'h0, mem_model(32'h80), 2);
      push(1'b0, 1'b0, 32'h20, 32'h0, mem_model(32'h20), 2);
    end
`else
    for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 32'h80, 32'h0, mem_model(32'h80), 2);
`endif
    if_req = 1'b1; d_req = 1'b1;
    wait_done();
    if_sticky = 1'b0; d_sticky = 1'b0;

    // ack on the last cycle before timeout
    mem_lat = TO;
    d_we = 1'b0; d_addr = 32'h100; d_req = 1'b1;
    push(1'b1, 1'b0, 32'h100, 32'h0, mem_model(32'h100), TO);
    wait_done();
    chk_val("terr_after_late_ack", 64'(timeout_err), 64'(0));

    // no ack: timeout with zero read data
    mem_lat = 0;
    d_addr = 32'h200; d_req = 1'b1;
    push(1'b1, 1'b0, 32'h200, 32'h0, 32'h0, TO);
    wait_done();
    chk_val("terr_after_timeout", 64'(timeout_err), 64'(1));

    mem_lat = 2;
    if_addr = 32'h30; if_req = 1'b1;
    push(1'b0, 1'b0, 32'h30, 32'h0, mem_model(32'h30), 2);
    wait_done();
    chk_val("terr_sticky", 64'(timeout_err), 64'(1));

    // reset in the second grant cycle abandons the access
    mem_lat = 0;
    if_addr = 32'h50; if_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_read && mcnt == 2) break;
    end
    chk_val("reached_grant2", 64'(mcnt), 64'(2));
    reset = 1'b1; if_req = 1'b0;
    step();
    chk_val("rst_flags", 64'({mem_read, mem_write, busy, grant_d, timeout_err, if_done, d_done}), 64'(0));
    chk_val("rst_addr", 64'(mem_addr), 64'(0));
    reset = 1'b0;
    step();

    mem_lat = 1;
    if_addr = 32'h60; if_req = 1'b1;
    push(1'b0, 1'b0, 32'h60, 32'h0, mem_model(32'h60), 1);
    wait_done();
    chk_val("terr_clear_after_rst", 64'(timeout_err), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
